// File: rtl/apb_agent_pkg.sv
// rtl/apb_agent_pkg.sv - shared APB types and arbiter state encoding
package apb_agent_pkg;

  localparam int APB_PROT_WIDTH = 3;

  typedef logic [APB_PROT_WIDTH-1:0] apb_pprot_t;

  typedef enum logic {
    APB_READ  = 1'b0,
    APB_WRITE = 1'b1
  } apb_write_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_arb_state_e;

endpackage

// File: rtl/apb_rr_arbiter.sv
// rtl/apb_rr_arbiter.sv - combinational round-robin search starting after the last winner
module apb_rr_arbiter #(
  parameter int N    = 4,
  parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx
);

  logic [IDXW-1:0] cand;
  logic            found;

  // Walk ptr+1, ptr+2, ... modulo N and take the first pending request
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IDXW'((int'(ptr) + i) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - shares one APB requester among NUM_REQ channels; APB_REQ_ARBITER_TIMEOUT_EN adds an ACCESS wait limit
module apb_req_arbiter
  import apb_agent_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                  pclk,
  input  logic                                  preset_n,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]         req_addr,
  input  logic [NUM_REQ-1:0]                    req_write,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]         req_wdata,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]     req_strb,
  input  logic [NUM_REQ*APB_PROT_WIDTH-1:0]     req_prot,
  output logic [NUM_REQ-1:0]                    rsp_valid,
  output logic [DATA_WIDTH-1:0]                 rsp_rdata,
  output logic                                  rsp_err,
  output logic [ADDR_WIDTH-1:0]                 paddr,
  output logic [APB_PROT_WIDTH-1:0]             pprot,
  output logic                                  psel,
  output logic                                  penable,
  output logic                                  pwrite,
  output logic [DATA_WIDTH-1:0]                 pwdata,
  output logic [DATA_WIDTH/8-1:0]               pstrb,
  input  logic                                  pready,
  input  logic [DATA_WIDTH-1:0]                 prdata,
  input  logic                                  pslverr
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("apb_req_arbiter: NUM_REQ must be within 2..16");
  end
  if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
    $error("apb_req_arbiter: DATA_WIDTH must be a multiple of 8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_req_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  apb_arb_state_e          state_q;
  apb_arb_state_e          state_d;
  logic [IDX_WIDTH-1:0]    ptr_q;
  logic [NUM_REQ-1:0]      gnt;
  logic [IDX_WIDTH-1:0]    gnt_idx;
  logic                    arb_en;
  logic                    accept;
  logic                    complete;
  logic                    timeout;

  logic [ADDR_WIDTH-1:0]   lat_addr_q;
  apb_write_t              lat_write_q;
  logic [DATA_WIDTH-1:0]   lat_wdata_q;
  logic [STRB_WIDTH-1:0]   lat_strb_q;
  apb_pprot_t              lat_prot_q;

  apb_rr_arbiter #(
    .N    (NUM_REQ),
    .IDXW (IDX_WIDTH)
  ) u_rr (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

`ifdef APB_REQ_ARBITER_TIMEOUT_EN
  localparam int WAIT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_WIDTH-1:0] wait_cnt_q;

  // Count stalled ACCESS cycles of the current transfer; SETUP restarts the count
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      wait_cnt_q <= '0;
    end else if (state_q == SETUP) begin
      wait_cnt_q <= '0;
    end else if (state_q == ACCESS && !pready) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  // A late pready on the limit cycle still completes the transfer normally
  assign timeout = (state_q == ACCESS) && !pready &&
                   (wait_cnt_q == WAIT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // Next state; arbitration is open in IDLE and on the completing ACCESS cycle
  always_comb begin
    state_d = state_q;
    arb_en  = 1'b0;
    case (state_q)
      IDLE: begin
        arb_en = 1'b1;
        if (|gnt) state_d = SETUP;
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          arb_en  = 1'b1;
          state_d = (|gnt) ? SETUP : IDLE;
        end else if (timeout) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign accept    = arb_en && (|gnt);
  assign complete  = (state_q == ACCESS) && pready;
  assign req_ready = (arb_en && preset_n) ? gnt : '0;

  // State register; reset drops the bus in the same instant
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the winner's payload and move the round-robin pointer onto it
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      ptr_q       <= IDX_WIDTH'(NUM_REQ - 1);
      lat_addr_q  <= '0;
      lat_write_q <= APB_READ;
      lat_wdata_q <= '0;
      lat_strb_q  <= '0;
      lat_prot_q  <= '0;
    end else if (accept) begin
      ptr_q       <= gnt_idx;
      lat_addr_q  <= req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
      lat_write_q <= apb_write_t'(req_write[gnt_idx]);
      lat_wdata_q <= req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
      lat_strb_q  <= req_write[gnt_idx] ? req_strb[gnt_idx*STRB_WIDTH +: STRB_WIDTH] : '0;
      lat_prot_q  <= apb_pprot_t'(req_prot[gnt_idx*APB_PROT_WIDTH +: APB_PROT_WIDTH]);
    end
  end

  // One-cycle completion pulse to the channel that owns the finishing transfer
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (complete) begin
      rsp_valid <= NUM_REQ'(1) << ptr_q;
      rsp_rdata <= (lat_write_q == APB_WRITE) ? '0 : prdata;
      rsp_err   <= pslverr;
    end else if (timeout) begin
      rsp_valid <= NUM_REQ'(1) << ptr_q;
      rsp_rdata <= '0;
      rsp_err   <= 1'b1;
    end else begin
      rsp_valid <= '0;
    end
  end

  assign psel    = (state_q != IDLE);
  assign penable = (state_q == ACCESS);
  assign paddr   = lat_addr_q;
  assign pwrite  = (lat_write_q == APB_WRITE);
  assign pwdata  = lat_wdata_q;
  assign pstrb   = lat_strb_q;
  assign pprot   = lat_prot_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb/tb_apb_req_arbiter.sv - scoreboard bench for apb_req_arbiter; APB_REQ_ARBITER_TIMEOUT_EN enables the timeout case
module tb_apb_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;
`ifdef APB_REQ_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            pclk = 1'b0;
  logic            preset_n;
  logic [N-1:0]    req_valid, req_ready, req_write, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_strb;
  logic [N*3-1:0]  req_prot;
  logic [DW-1:0]   rsp_rdata, pwdata, prdata;
  logic            rsp_err, psel, penable, pwrite, pready, pslverr;
  logic [AW-1:0]   paddr;
  logic [2:0]      pprot;
  logic [SW-1:0]   pstrb;

  always #5 pclk = ~pclk;

  apb_req_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(N), .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk(pclk), .preset_n(preset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
    .req_prot(req_prot), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .paddr(paddr), .pprot(pprot), .psel(psel),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  typedef struct {
    int            ch;
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    logic [2:0]    prot;
  } txn_t;

  typedef struct {
    int            ch;
    logic [DW-1:0] rdata;
    logic          err;
    int            due;
  } rsp_t;

  rsp_t  rsp_q[$];
  int    grant_ch[$];
  int    n_checks = 0, n_fail = 0;
  int    cyc = 0, phase = 0, last = N - 1, acc_cnt = 0;
  txn_t  cur;
  logic [N-1:0]  acc_mask = '0;
  int    rsp_cnt = 0, pen_cnt = 0, last_rsp_cyc = 0, last_grant_cyc = 0;
  int    grant_cyc_log[$];
  logic [N-1:0]  last_rsp_valid = '0;
  logic [DW-1:0] last_rsp_rdata = '0;
  logic          last_rsp_err = 1'b0;

  int            cfg_wait = 0, cfg_err = 0, wait_left = 0;
  logic [DW-1:0] cfg_rdata = '0;
  bit            cfg_rdata_rand = 1'b0, rand_on = 1'b0, hold_all = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Round-robin rule: first pending channel after the previous winner
  function automatic int rr_pick(input logic [N-1:0] v, input int from);
    for (int k = 1; k <= N; k++) if (v[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  task automatic take(input int p);
    cur.ch    = p;
    cur.addr  = req_addr[p*AW +: AW];
    cur.wr    = req_write[p];
    cur.wdata = req_wdata[p*DW +: DW];
    cur.strb  = req_strb[p*SW +: SW];
    cur.prot  = req_prot[p*3 +: 3];
    last = p;
    last_grant_cyc = cyc;
    grant_ch.push_back(p);
    grant_cyc_log.push_back(cyc);
  endtask

  // Monitor: compares the bus and responses against the transaction model
  always @(negedge pclk) begin : monitor
    logic [N-1:0] exp_ready;
    int           p;
    rsp_t         r;
    cyc++;
    if (penable) pen_cnt++;
    if (rsp_valid != '0) begin
      rsp_cnt++;
      last_rsp_cyc   = cyc;
      last_rsp_valid = rsp_valid;
      last_rsp_rdata = rsp_rdata;
      last_rsp_err   = rsp_err;
    end
    if (!preset_n) begin
      chk("reset_outputs", {req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable,
                            pwrite, paddr, pwdata, pstrb, pprot}, '0);
      phase = 0; last = N - 1; acc_cnt = 0; acc_mask = '0;
      rsp_q.delete();
    end else begin
      p = rr_pick(req_valid, last);
      exp_ready = '0;
      if ((phase == 0 || (phase == 2 && pready)) && p >= 0) exp_ready[p] = 1'b1;
      chk("req_ready", req_ready, exp_ready);
      chk("psel", psel, phase != 0);
      chk("penable", penable, phase == 2);
      if (phase != 0) begin
        chk("paddr", paddr, cur.addr);
        chk("pwrite", pwrite, cur.wr);
        chk("pwdata", pwdata, cur.wdata);
        chk("pstrb", pstrb, cur.wr ? cur.strb : '0);
        chk("pprot", pprot, cur.prot);
      end
      if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
        r = rsp_q.pop_front();
        chk("rsp_valid", rsp_valid, N'(1) << r.ch);
        chk("rsp_rdata", rsp_rdata, r.rdata);
        chk("rsp_err", rsp_err, r.err);
      end else begin
        chk("rsp_quiet", rsp_valid, '0);
      end
      acc_mask = req_ready & req_valid;
      case (phase)
        0: if (exp_ready != '0) begin take(p); phase = 1; end
        1: begin phase = 2; acc_cnt = 0; end
        default: begin
          acc_cnt++;
          if (pready) begin
            r.ch = cur.ch; r.rdata = cur.wr ? '0 : prdata; r.err = pslverr; r.due = cyc + 1;
            rsp_q.push_back(r);
            if (exp_ready != '0) begin take(p); phase = 1; end
            else phase = 0;
          end else if (TO_EN && acc_cnt == TO) begin
            r.ch = cur.ch; r.rdata = '0; r.err = 1'b1; r.due = cyc + 1;
            rsp_q.push_back(r);
            phase = 0;
          end
        end
      endcase
    end
  end

  task automatic load_req(input int i, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [SW-1:0] s, input logic [2:0] pr);
    req_addr[i*AW +: AW]  = a;
    req_write[i]          = wr;
    req_wdata[i*DW +: DW] = d;
    req_strb[i*SW +: SW]  = s;
    req_prot[i*3 +: 3]    = pr;
    req_valid[i]          = 1'b1;
  endtask

  task automatic load_rand(input int i);
    load_req(i, 1'($urandom), $urandom, $urandom, SW'($urandom), 3'($urandom));
  endtask

  // One clock: slave response then channel drivers, all just after the edge
  task automatic tick();
    @(posedge pclk);
    #1;
    if (psel && !penable) wait_left = (cfg_wait < 0) ? int'($urandom_range(0, 3)) : cfg_wait;
    if (psel && penable && wait_left > 0) begin
      pready = 1'b0; wait_left--; prdata = $urandom; pslverr = 1'($urandom);
    end else if (psel && penable) begin
      pready  = 1'b1;
      prdata  = cfg_rdata_rand ? $urandom : cfg_rdata;
      pslverr = (cfg_err < 0) ? 1'($urandom) : 1'(cfg_err);
    end else begin
      pready = 1'($urandom); prdata = $urandom; pslverr = 1'($urandom);
    end
    for (int i = 0; i < N; i++) begin
      if (acc_mask[i]) req_valid[i] = 1'b0;
      if (hold_all && !req_valid[i]) load_rand(i);
      else if (rand_on && !req_valid[i] && $urandom_range(0, 3) == 0) load_rand(i);
      else if (rand_on && req_valid[i] && $urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
    end
  endtask

  task automatic wait_rsp(input int budget, input string name);
    int start = rsp_cnt;
    for (int k = 0; k < budget && rsp_cnt == start; k++) tick();
    chk(name, rsp_cnt != start, 1'b1);
  endtask

  initial begin
    int old, n;
    preset_n = 1'b0;
    req_valid = '0; req_addr = '0; req_write = '0; req_wdata = '0;
    req_strb = '0; req_prot = '0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
    repeat (3) tick();
    preset_n = 1'b1;

    cfg_wait = 0; cfg_err = 0; cfg_rdata = 32'hCAFE_F00D;
    load_req(0, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 3'd0);
    wait_rsp(20, "write_rsp_seen");
    chk("write_latency", last_rsp_cyc - last_grant_cyc, 3);
    chk("write_rsp_valid", last_rsp_valid, 4'b0001);
    chk("write_rsp_err", last_rsp_err, 1'b0);
    tick();

    cfg_wait = 3; cfg_rdata = 32'h1234_5678; pen_cnt = 0;
    load_req(1, 1'b0, 32'h2000, 32'h5555_AAAA, 4'hF, 3'd2);
    wait_rsp(20, "read_rsp_seen");
    chk("read_penable_cycles", pen_cnt, 4);
    chk("read_rsp_valid", last_rsp_valid, 4'b0010);
    chk("read_rdata", last_rsp_rdata, 32'h1234_5678);

    cfg_wait = 0; cfg_err = 1;
    load_req(2, 1'b0, 32'h3000, 32'h0, 4'h3, 3'd1);
    wait_rsp(20, "err_rsp_seen");
    chk("err_rsp_valid", last_rsp_valid, 4'b0100);
    chk("err_rsp_err", last_rsp_err, 1'b1);
    cfg_err = 0;

    cfg_wait = 10;
    load_req(1, 1'b0, 32'h4000, 32'h0, 4'h0, 3'd0);
    for (int k = 0; k < 20 && !penable; k++) tick();
    chk("reset_reached_access", penable, 1'b1);
    tick(); tick();
    old = rsp_cnt;
    #2 preset_n = 1'b0;
    #1;
    chk("async_reset_psel", psel, 1'b0);
    chk("async_reset_penable", penable, 1'b0);
    req_valid = '0;
    load_req(3, 1'b1, 32'h3333, 32'h3, 4'h1, 3'd3);
    load_req(0, 1'b1, 32'h0000, 32'h0, 4'h2, 3'd0);
    tick(); tick();
    preset_n = 1'b1;
    cfg_wait = 0;
    n = grant_ch.size();
    for (int k = 0; k < 10 && grant_ch.size() == n; k++) tick();
    chk("post_reset_grant_seen", grant_ch.size() > n, 1'b1);
    if (grant_ch.size() > n) chk("post_reset_first_grant", grant_ch[n], 0);
    repeat (20) tick();
    chk("reset_lost_transfer", rsp_cnt - old, 2);

    preset_n = 1'b0;
    tick();
    preset_n = 1'b1;
    hold_all = 1'b1;
    n = grant_ch.size();
    for (int k = 0; k < 40 && grant_ch.size() < n + 5; k++) tick();
    hold_all = 1'b0;
    chk("contention_grants_seen", grant_ch.size() >= n + 5, 1'b1);
    if (grant_ch.size() >= n + 5) begin
      for (int k = 0; k < 5; k++) chk($sformatf("contention_order_%0d", k), grant_ch[n + k], k % N);
      for (int k = 1; k < 5; k++)
        chk($sformatf("contention_spacing_%0d", k), grant_cyc_log[n + k] - grant_cyc_log[n + k - 1], 2);
    end
    repeat (30) tick();

    rand_on = 1'b1; cfg_wait = -1; cfg_err = -1; cfg_rdata_rand = 1'b1;
    repeat (3000) tick();
    rand_on = 1'b0;
    repeat (60) tick();
    chk("random_drained", rsp_q.size(), 0);

`ifdef APB_REQ_ARBITER_TIMEOUT_EN
    cfg_wait = 100; cfg_err = 0; cfg_rdata_rand = 1'b0; cfg_rdata = 32'hFFFF_0000;
    load_req(3, 1'b0, 32'h5000, 32'h0, 4'h0, 3'd0);
    wait_rsp(40, "timeout_rsp_seen");
    chk("timeout_latency", last_rsp_cyc - last_grant_cyc, TO + 2);
    chk("timeout_rsp_valid", last_rsp_valid, 4'b1000);
    chk("timeout_rsp_err", last_rsp_err, 1'b1);
    chk("timeout_rsp_rdata", last_rsp_rdata, '0);
    chk("timeout_idle_psel", psel, 1'b0);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Shares one APB requester port among NUM_REQ local request channels.
- Arbitrates round-robin, latches the winning request, and sequences the APB SETUP and ACCESS phases.
- Returns read data and the error status to the granted channel.
- Sits between testbench or DUT-side request sources and the apb_vip_if signal set; it drives every requester signal and samples every completer signal.

Parameters:
- ADDR_WIDTH, 32, paddr width.
- DATA_WIDTH, 32, pwdata/prdata width; multiple of 8.
- NUM_REQ, 4, number of request channels; range 2..16.
- TIMEOUT_CYCLES, 256, ACCESS-phase wait limit; used only with the optional feature.

Ports:
- pclk  in  1  APB clock.
- preset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-channel request pending.
- req_ready  out  NUM_REQ  one-hot accept; combinational.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed per-channel address.
- req_write  in  NUM_REQ  1 = write.
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- req_strb  in  NUM_REQ*(DATA_WIDTH/8)  packed write strobes.
- req_prot  in  NUM_REQ*3  packed pprot.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  read data; valid while rsp_valid is nonzero.
- rsp_err  out  1  slave error or timeout; valid while rsp_valid is nonzero.
- paddr, pprot, psel, penable, pwrite, pwdata, pstrb  out  per APB  requester signals.
- pready, prdata, pslverr  in  per APB  completer signals.

Behaviour:
- Clocking and reset:
  - Single clock, pclk.
  - Reset: preset_n is asynchronous active-low.
  - On reset, all outputs go to 0, the FSM goes to IDLE, and the round-robin pointer goes to NUM_REQ-1, so channel 0 has first priority.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - Arbitration is active; req_ready is the grant one-hot AND req_valid.
  - Search order is ptr+1, ptr+2, … modulo NUM_REQ.
  - On an edge with a grant:
    - latch addr, write, wdata, strb, prot;
    - ptr becomes the granted index;
    - next state is SETUP.
- SETUP:
  - psel=1, penable=0; registered APB outputs show the latched request.
  - Next state is ACCESS unconditionally.
- ACCESS:
  - psel=1, penable=1; the bus is held stable.
  - pready=0: stay in ACCESS.
  - pready=1: register prdata (reads only; writes return 0) and pslverr.
  - The next cycle pulses rsp_valid[grant] with rsp_rdata/rsp_err.
- Back-to-back: in an ACCESS cycle with pready=1, arbitration is also active.
  - If any req_valid is set, req_ready pulses and the next state is SETUP directly; psel stays 1 and penable drops to 0.
  - Otherwise the next state is IDLE with psel=0 and penable=0.
- Latency: accept at edge T → SETUP in cycle T+1 → ACCESS in T+2 → with zero wait states, rsp_valid in T+3.
- Throughput: one transfer per 2 cycles under continuous demand.
- pstrb is forced to 0 on reads. pwdata is held at the latched value for reads (don't-care to the slave).
- Channel protocol: a channel holds req_valid and its payload stable until req_ready. A channel may drop req_valid before grant; it is then not granted.
- A channel's rsp_valid pulse may coincide with a new req_ready for the same channel.
- Reset mid-transfer: the bus deasserts immediately, no rsp_valid is issued, and the transfer is lost.
- The selected index is always within 0..NUM_REQ-1. req_ready and rsp_valid are never multi-hot.

Optional Feature:
- Macro: APB_REQ_ARBITER_TIMEOUT_EN.
- Defined:
  - An ACCESS wait counter resets on each SETUP entry.
  - If pready is still 0 after TIMEOUT_CYCLES ACCESS cycles, the transfer is terminated:
    - psel=0 and penable=0 next cycle;
    - rsp_valid pulses with rsp_err=1 and rsp_rdata=0;
    - next state is IDLE, with no back-to-back.
  - pready arriving in the same cycle as the limit wins; it completes normally.
- Undefined: no counter; ACCESS waits indefinitely for pready.

Decomposition:
- Shared package apb_agent_pkg: apb_pprot_t, apb_write_t, the FSM enum apb_arb_state_e (IDLE/SETUP/ACCESS), and the constant APB_PROT_WIDTH=3.
- Sub-module apb_rr_arbiter: parameter N; inputs req[N], ptr; output one-hot gnt and gnt_idx; purely combinational round-robin search.
- The FSM, latches, and timeout counter stay in apb_req_arbiter.

Test Plan:
- Single write, zero-wait:
  - Stimulus: req0 write, addr 0x100, wdata 0xDEADBEEF, strb 0xF, pready=1.
  - Required: psel at T+1, penable at T+2, pstrb=0xF, rsp_valid=0001 at T+3, rsp_err=0.
- Read with 3 wait states:
  - Stimulus: req1 read, addr 0x2000, pready low for 3 ACCESS cycles then high with prdata 0x12345678.
  - Required: penable=1 for 4 cycles, pstrb=0, rsp_valid=0010, rsp_rdata=0x12345678.
- Full contention:
  - Stimulus: all 4 channels valid continuously, pready=1.
  - Required: grants 0,1,2,3,0 in order; psel never drops; penable toggles 0,1 each cycle.
- Slave error:
  - Stimulus: req2 read, pslverr=1 with pready.
  - Required: rsp_valid=0100, rsp_err=1.
- Reset in ACCESS:
  - Stimulus: preset_n driven low mid-wait.
  - Required: psel=0 and penable=0 immediately (no edge needed); no rsp_valid; after release, with req0 and req3 both valid, req0 is granted first.
- Timeout (macro defined):
  - Stimulus: TIMEOUT_CYCLES=16, pready held 0.
  - Required: termination after 16 ACCESS cycles; rsp_err=1, rsp_rdata=0; state returns to IDLE.
